crop_frame_sequencer: RTL and testbench

//  Per-frame controller for the crop datapath. Generates cnt_col/cnt_row from input-stream handshakes.

---
 rtl/crop_frame_sequencer_pkg.sv | 16 +
 rtl/crop_frame_sequencer_if.sv | 36 +++
 rtl/crop_pixel_counter.sv | 54 +++++
 rtl/crop_frame_sequencer.sv | 134 +++++++++++++
 tb/tb_crop_frame_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/crop_frame_sequencer_pkg.sv
// Shared types and helpers for the crop frame sequencer and its pixel counter.
package crop_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } crop_seq_state_t;

  // Keeps the crop window inside the input frame.
  function automatic int unsigned clamp_origin(input int unsigned req, input int unsigned max_origin);
    return (req > max_origin) ? max_origin : req;
  endfunction

endpackage

// File: rtl/crop_frame_sequencer_if.sv
// Control/observation bundle between the crop filter environment (master) and the sequencer (slave).
interface crop_frame_sequencer_if #(
  parameter int unsigned USER_WIDTH = 2,
  parameter int unsigned IN_ROWS    = 20,
  parameter int unsigned IN_COLS    = 20
);
  logic                       ap_start;
  logic                       ap_done;
  logic                       ap_idle;
  logic                       ap_ready;
  logic [$clog2(IN_COLS)-1:0] cfg_crop_x0;
  logic [$clog2(IN_ROWS)-1:0] cfg_crop_y0;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [USER_WIDTH-1:0]      s_axis_tuser;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       frame_en;
  logic [$clog2(IN_COLS)-1:0] crop_x0;
  logic [$clog2(IN_ROWS)-1:0] crop_y0;
  logic [$clog2(IN_COLS)-1:0] cnt_col;
  logic [$clog2(IN_ROWS)-1:0] cnt_row;
  logic                       sof_err;

  modport master (
    output ap_start, cfg_crop_x0, cfg_crop_y0,
    output s_axis_tvalid, s_axis_tready, s_axis_tuser, m_axis_tvalid, m_axis_tready,
    input  ap_done, ap_idle, ap_ready, frame_en, crop_x0, crop_y0, cnt_col, cnt_row, sof_err
  );

  modport slave (
    input  ap_start, cfg_crop_x0, cfg_crop_y0,
    input  s_axis_tvalid, s_axis_tready, s_axis_tuser, m_axis_tvalid, m_axis_tready,
    output ap_done, ap_idle, ap_ready, frame_en, crop_x0, crop_y0, cnt_col, cnt_row, sof_err
  );
endinterface

// File: rtl/crop_pixel_counter.sv
// Column/row raster counter; outputs show the current pixel, registers hold the next one.
module crop_pixel_counter #(
  parameter int unsigned ROWS = 20,
  parameter int unsigned COLS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc_i,
  input  logic                    sync_clear_i,
  output logic [$clog2(COLS)-1:0] col_o,
  output logic [$clog2(ROWS)-1:0] row_o,
  output logic                    at_origin_o,
  output logic                    col_wrap_o,
  output logic                    frame_wrap_o
);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic [COL_W-1:0] col_q, col_d, colBase;
  logic [ROW_W-1:0] row_q, row_d, rowBase;

  // A sync clear bypasses the registers so the clearing beat itself reads as (0,0).
  always_comb begin
    colBase      = sync_clear_i ? '0 : col_q;
    rowBase      = sync_clear_i ? '0 : row_q;
    col_wrap_o   = (colBase == COL_W'(COLS - 1));
    frame_wrap_o = col_wrap_o && (rowBase == ROW_W'(ROWS - 1));
    col_d        = colBase;
    row_d        = rowBase;
    if (inc_i) begin
      if (col_wrap_o) begin
        col_d = '0;
        row_d = (rowBase == ROW_W'(ROWS - 1)) ? '0 : rowBase + ROW_W'(1);
      end else begin
        col_d = colBase + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o       = colBase;
  assign row_o       = rowBase;
  assign at_origin_o = (col_q == '0) && (row_q == '0);

endmodule

// File: rtl/crop_frame_sequencer.sv
// Per-frame crop controller: pixel counters, clamped origin latch and ap_* handshake.
// Optional DRAIN watchdog is built when CROP_SEQ_TIMEOUT_EN is defined.
module crop_frame_sequencer
  import crop_frame_sequencer_pkg::*;
#(
  parameter int unsigned USER_WIDTH = 2,
  parameter int unsigned IN_ROWS    = 20,
  parameter int unsigned IN_COLS    = 20,
  parameter int unsigned OUT_ROWS   = 10,
  parameter int unsigned OUT_COLS   = 10
) (
  input logic                   clk,
  input logic                   s_axis_resetn,
  crop_frame_sequencer_if.slave bus
);
  localparam int unsigned COL_W  = $clog2(IN_COLS);
  localparam int unsigned ROW_W  = $clog2(IN_ROWS);
  localparam int unsigned TARGET = OUT_ROWS * OUT_COLS;
  localparam int unsigned OC_W   = $clog2(TARGET + 1);
  localparam int unsigned MAX_X0 = IN_COLS - OUT_COLS;
  localparam int unsigned MAX_Y0 = IN_ROWS - OUT_ROWS;

  crop_seq_state_t  state_q;
  logic [COL_W-1:0] cropX0_q;
  logic [ROW_W-1:0] cropY0_q;
  logic [OC_W-1:0]  outCnt_q, outCnt_d;
  logic             apDone_q, apReady_q, apIdle_q, sofErr_q;
  logic             sBeat, sofBeat, mBeat, accept, cntInc, cntClear, drainDone, wdogFire;
  logic             atOrigin, frameWrap, col_wrap_unused, user_unused;
  logic [COL_W-1:0] colPos;
  logic [ROW_W-1:0] rowPos;

  assign user_unused = ^bus.s_axis_tuser[USER_WIDTH-1:0];

  // Output beats saturate at the target so stray extra beats cannot wrap the count.
  always_comb begin
    sBeat    = bus.s_axis_tvalid & bus.s_axis_tready;
    sofBeat  = sBeat & bus.s_axis_tuser[0];
    mBeat    = bus.m_axis_tvalid & bus.m_axis_tready;
    accept   = (state_q == IDLE) & bus.ap_start;
    cntInc   = ((state_q == ARM) & sofBeat) | ((state_q == RUN) & sBeat);
    cntClear = accept | (((state_q == ARM) | (state_q == RUN)) & sofBeat);
    outCnt_d = outCnt_q;
    if (((state_q == RUN) | (state_q == DRAIN)) & mBeat & (outCnt_q != OC_W'(TARGET)))
      outCnt_d = outCnt_q + OC_W'(1);
    drainDone = (outCnt_d == OC_W'(TARGET));
  end

  crop_pixel_counter #(
    .ROWS (IN_ROWS),
    .COLS (IN_COLS)
  ) u_counter (
    .clk          (clk),
    .rst_n        (s_axis_resetn),
    .inc_i        (cntInc),
    .sync_clear_i (cntClear),
    .col_o        (colPos),
    .row_o        (rowPos),
    .at_origin_o  (atOrigin),
    .col_wrap_o   (col_wrap_unused),
    .frame_wrap_o (frameWrap)
  );

`ifdef CROP_SEQ_TIMEOUT_EN
  logic [15:0] wdog_q;

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn)
      wdog_q <= '0;
    else if ((state_q != DRAIN) || mBeat)
      wdog_q <= '0;
    else
      wdog_q <= wdog_q + 16'd1;
  end

  assign wdogFire = (state_q == DRAIN) && (wdog_q == 16'hFFFF);
`else
  assign wdogFire = 1'b0;
`endif

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q   <= IDLE;
      cropX0_q  <= '0;
      cropY0_q  <= '0;
      outCnt_q  <= '0;
      apDone_q  <= 1'b0;
      apReady_q <= 1'b0;
      apIdle_q  <= 1'b1;
      sofErr_q  <= 1'b0;
    end else begin
      apDone_q  <= 1'b0;
      apReady_q <= 1'b0;
      sofErr_q  <= 1'b0;
      outCnt_q  <= outCnt_d;
      unique case (state_q)
        IDLE: if (accept) begin
          apReady_q <= 1'b1;
          apIdle_q  <= 1'b0;
          cropX0_q  <= COL_W'(clamp_origin(32'(bus.cfg_crop_x0), MAX_X0));
          cropY0_q  <= ROW_W'(clamp_origin(32'(bus.cfg_crop_y0), MAX_Y0));
          outCnt_q  <= '0;
          state_q   <= ARM;
        end
        ARM: if (sofBeat) state_q <= RUN;
        // A misplaced SOF resyncs the counters and keeps the frame running.
        RUN: begin
          if (sofBeat && !atOrigin)
            sofErr_q <= 1'b1;
          else if (sBeat && frameWrap)
            state_q <= DRAIN;
        end
        DRAIN: if (drainDone || wdogFire) begin
          apDone_q <= 1'b1;
          sofErr_q <= wdogFire;
          apIdle_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ap_done  = apDone_q;
  assign bus.ap_ready = apReady_q;
  assign bus.ap_idle  = apIdle_q;
  assign bus.sof_err  = sofErr_q;
  assign bus.crop_x0  = cropX0_q;
  assign bus.crop_y0  = cropY0_q;
  assign bus.cnt_col  = colPos;
  assign bus.cnt_row  = rowPos;
  assign bus.frame_en = (state_q == RUN) | ((state_q == ARM) & sofBeat);

endmodule

// File: tb/tb_crop_frame_sequencer.sv
// Directed bench for crop_frame_sequencer with a pixel-position scoreboard on every input beat.
module tb_crop_frame_sequencer;
  localparam int IN_ROWS   = 20;
  localparam int IN_COLS   = 20;
  localparam int OUT_ROWS  = 10;
  localparam int OUT_COLS  = 10;
  localparam int FRAME_PIX = IN_ROWS * IN_COLS;

  typedef struct {
    int row;
    int col;
  } pixPos_t;

  logic    clk = 1'b0;
  logic    rstN;
  int      assertCount = 0;
  int      failCount = 0;
  int      doneAt, readyAt, doneSeen;
  pixPos_t expQ[$];

  crop_frame_sequencer_if #(.USER_WIDTH(2), .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS)) bus ();

  crop_frame_sequencer #(
    .USER_WIDTH (2),
    .IN_ROWS    (IN_ROWS),
    .IN_COLS    (IN_COLS),
    .OUT_ROWS   (OUT_ROWS),
    .OUT_COLS   (OUT_COLS)
  ) dut (
    .clk           (clk),
    .s_axis_resetn (rstN),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle just after the clock edge and returns at the following falling edge.
  task automatic applyStimulus(input logic sValid, input logic sofFlag, input logic mValid, input logic mReady);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = sValid;
    bus.s_axis_tready = 1'b1;
    bus.s_axis_tuser  = {1'b0, sofFlag};
    bus.m_axis_tvalid = mValid;
    bus.m_axis_tready = mReady;
    @(negedge clk);
  endtask

  task automatic sendPixel(input int row, input int col, input logic sofFlag, input logic mValid, input logic mReady);
    pixPos_t e;
    e.row = row;
    e.col = col;
    expQ.push_back(e);
    applyStimulus(1'b1, sofFlag, mValid, mReady);
    e = expQ.pop_front();
    checkOutput("cnt_row", 32'(bus.cnt_row), e.row);
    checkOutput("cnt_col", 32'(bus.cnt_col), e.col);
    checkOutput("frame_en", 32'(bus.frame_en), 1);
  endtask

  task automatic waitForReady(output int doneIdx, output int readyIdx);
    doneIdx  = -1;
    readyIdx = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (bus.ap_done) doneIdx = i;
      if (bus.ap_ready) begin
        readyIdx = i;
        break;
      end
    end
  endtask

  initial begin
    rstN              = 1'b0;
    bus.ap_start      = 1'b0;
    bus.cfg_crop_x0   = '0;
    bus.cfg_crop_y0   = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tready = 1'b0;
    bus.s_axis_tuser  = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_ap_idle", 32'(bus.ap_idle), 1);
    checkOutput("rst_ap_done", 32'(bus.ap_done), 0);
    checkOutput("rst_ap_ready", 32'(bus.ap_ready), 0);
    checkOutput("rst_sof_err", 32'(bus.sof_err), 0);
    checkOutput("rst_cnt_col", 32'(bus.cnt_col), 0);
    checkOutput("rst_crop_x0", 32'(bus.crop_x0), 0);
    rstN = 1'b1;

    // Frame A: origin 0, no backpressure, 100th output beat held back into DRAIN.
    bus.ap_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("A_ap_ready", 32'(bus.ap_ready), 1);
    checkOutput("A_ap_idle", 32'(bus.ap_idle), 0);
    checkOutput("A_crop_y0", 32'(bus.crop_y0), 0);
    bus.ap_start = 1'b0;
    for (int k = 0; k < FRAME_PIX; k++)
      sendPixel(k / IN_COLS, k % IN_COLS, 1'(k == 0), 1'((k >= 1) && (k <= 99)), 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("A_drain_ap_done", 32'(bus.ap_done), 0);
      checkOutput("A_drain_ap_idle", 32'(bus.ap_idle), 0);
      checkOutput("A_drain_cnt_row", 32'(bus.cnt_row), 0);
      checkOutput("A_drain_frame_en", 32'(bus.frame_en), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("A_last_beat_ap_done", 32'(bus.ap_done), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("A_ap_done", 32'(bus.ap_done), 1);
    checkOutput("A_done_ap_idle", 32'(bus.ap_idle), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("A_ap_done_width", 32'(bus.ap_done), 0);

    // Frame B: clamped origin, cfg change mid-frame, ARM noise, misplaced SOF.
    bus.cfg_crop_x0 = 5'd15;
    bus.cfg_crop_y0 = 5'd19;
    bus.ap_start    = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("B_ap_ready", 32'(bus.ap_ready), 1);
    checkOutput("B_crop_x0", 32'(bus.crop_x0), 10);
    checkOutput("B_crop_y0", 32'(bus.crop_y0), 10);
    bus.ap_start    = 1'b0;
    bus.cfg_crop_x0 = 5'd3;
    bus.cfg_crop_y0 = 5'd4;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("B_arm_cnt_col", 32'(bus.cnt_col), 0);
      checkOutput("B_arm_cnt_row", 32'(bus.cnt_row), 0);
      checkOutput("B_arm_frame_en", 32'(bus.frame_en), 0);
      checkOutput("B_arm_ap_ready", 32'(bus.ap_ready), 0);
    end
    for (int k = 0; k < 67; k++) begin
      sendPixel(k / IN_COLS, k % IN_COLS, 1'(k == 0), 1'b0, 1'b1);
      if (k == 66) checkOutput("B_pre_sof_err", 32'(bus.sof_err), 0);
    end
    sendPixel(0, 0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < FRAME_PIX; k++) begin
      sendPixel(k / IN_COLS, k % IN_COLS, 1'b0, 1'(k <= 100), 1'b1);
      if (k == 1) checkOutput("B_sof_err_pulse", 32'(bus.sof_err), 1);
      if (k == 2) checkOutput("B_sof_err_width", 32'(bus.sof_err), 0);
      if (k == 200) begin
        checkOutput("B_mid_crop_x0", 32'(bus.crop_x0), 10);
        checkOutput("B_mid_crop_y0", 32'(bus.crop_y0), 10);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("B_drain_ap_done", 32'(bus.ap_done), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("B_ap_done", 32'(bus.ap_done), 1);

    // Three back-to-back frames with ap_start held and random output backpressure.
    bus.ap_start = 1'b1;
    doneSeen     = 0;
    for (int f = 0; f < 3; f++) begin
      waitForReady(doneAt, readyAt);
      checkOutput("b2b_ap_ready_seen", 32'(readyAt >= 0), 1);
      if (f > 0) begin
        if (doneAt >= 0) doneSeen++;
        checkOutput("b2b_done_to_ready_gap", 32'(readyAt - doneAt), 1);
      end
      if (f == 2) bus.ap_start = 1'b0;
      for (int k = 0; k < FRAME_PIX; k++)
        sendPixel(k / IN_COLS, k % IN_COLS, 1'(k == 0), 1'b1, 1'($urandom_range(0, 1)));
    end
    doneAt = -1;
    for (int i = 0; (i < 20) && (doneAt < 0); i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      if (bus.ap_done) doneAt = i;
    end
    if (doneAt >= 0) doneSeen++;
    checkOutput("b2b_ap_done_count", 32'(doneSeen), 3);
    checkOutput("b2b_final_ap_idle", 32'(bus.ap_idle), 1);

    // Asynchronous reset in the middle of a running frame.
    bus.cfg_crop_x0 = 5'd12;
    bus.cfg_crop_y0 = 5'd5;
    bus.ap_start    = 1'b1;
    waitForReady(doneAt, readyAt);
    checkOutput("R_ap_ready_seen", 32'(readyAt >= 0), 1);
    checkOutput("R_crop_x0", 32'(bus.crop_x0), 10);
    checkOutput("R_crop_y0", 32'(bus.crop_y0), 5);
    bus.ap_start = 1'b0;
    for (int k = 0; k < 30; k++)
      sendPixel(k / IN_COLS, k % IN_COLS, 1'(k == 0), 1'b0, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("R_async_ap_idle", 32'(bus.ap_idle), 1);
    checkOutput("R_async_cnt_col", 32'(bus.cnt_col), 0);
    checkOutput("R_async_cnt_row", 32'(bus.cnt_row), 0);
    checkOutput("R_async_crop_x0", 32'(bus.crop_x0), 0);
    checkOutput("R_async_crop_y0", 32'(bus.crop_y0), 0);
    checkOutput("R_async_frame_en", 32'(bus.frame_en), 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("R_post_ap_idle", 32'(bus.ap_idle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
